// File: rtl/tone_pkg.sv
// Shared note codes and default half-period dividers, common to the tone
// generator and the tone detector.
package tone_pkg;

  localparam int CW = 17;

  // Half-periods in CLOCK_50 cycles for the three supported notes
  localparam int DIV_DO = 47778;
  localparam int DIV_RE = 42565;
  localparam int DIV_MI = 37922;

  typedef enum logic [1:0] {
    NOTE_NONE = 2'b00,
    NOTE_DO   = 2'b01,
    NOTE_RE   = 2'b10,
    NOTE_MI   = 2'b11
  } note_t;

  typedef enum logic {
    ST_SILENT = 1'b0,
    ST_TRACK  = 1'b1
  } det_state_t;

endpackage

// File: rtl/tone_detector_sync_edge.sv
// Two-flop synchronizer plus one delay flop; pulses edge_det for one cycle on
// every rising or falling transition of the asynchronous input.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_det
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 ^ s3;

endmodule

// File: rtl/tone_detector.sv
// Measures half-periods of a square-wave tone, classifies them as do/re/mi,
// and reports a note once STABLE consecutive classifications agree.
module tone_detector #(
  parameter int DIV_DO  = tone_pkg::DIV_DO,
  parameter int DIV_RE  = tone_pkg::DIV_RE,
  parameter int DIV_MI  = tone_pkg::DIV_MI,
  parameter int TOL     = 1000,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 100000,
  parameter int CW      = tone_pkg::CW
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          tone_in,
  output logic [1:0]    note,
  output logic          note_valid,
  output logic          note_change,
  output logic [CW-1:0] half_period
);

  import tone_pkg::*;

  localparam int RW = 4;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] DIV_DO_C  = CW'(DIV_DO);
  localparam logic [CW-1:0] DIV_RE_C  = CW'(DIV_RE);
  localparam logic [CW-1:0] DIV_MI_C  = CW'(DIV_MI);
  localparam logic [CW:0]   TOL_C     = (CW+1)'(TOL);
  localparam logic [RW-1:0] STABLE_C  = RW'(STABLE);

  // One bit of headroom keeps the difference from wrapping
  function automatic logic [CW:0] abs_diff(input logic [CW-1:0] a,
                                           input logic [CW-1:0] b);
    logic signed [CW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + CW'(1);
  endfunction

  function automatic logic [RW-1:0] sat_run(input logic [RW-1:0] r);
    return (r >= STABLE_C) ? STABLE_C : r + RW'(1);
  endfunction

  function automatic note_t classify(input logic [CW-1:0] m);
    if (abs_diff(m, DIV_DO_C) <= TOL_C) return NOTE_DO;
    else if (abs_diff(m, DIV_RE_C) <= TOL_C) return NOTE_RE;
    else if (abs_diff(m, DIV_MI_C) <= TOL_C) return NOTE_MI;
    else return NOTE_NONE;
  endfunction

  det_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  note_t         cand_q, cand_d;

  note_t         note_p1, note_d;
  logic          note_vld_p1, note_vld_d;
  logic          chg_p1, chg_d;
  logic [CW-1:0] hp_p1, hp_d;

  logic          edge_p0;
  logic [CW-1:0] meas_p0;
  note_t         cls_p0;
  note_t         cand_upd;
  logic [RW-1:0] run_upd;

  sync_edge u_sync_edge (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .din      (tone_in),
    .edge_det (edge_p0)
  );

  // Stage p0: measurement and classification of the edge in flight
  assign meas_p0 = cnt_q;
  assign cls_p0  = classify(meas_p0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    cand_d   = cand_q;
    note_d   = note_p1;
    chg_d    = 1'b0;
    hp_d     = hp_p1;
    cand_upd = cand_q;
    run_upd  = run_q;

    unique case (state_q)
      ST_SILENT: begin
        cnt_d = '0;
        if (edge_p0) begin
          state_d = ST_TRACK;
          cnt_d   = CW'(1);
        end
      end
      ST_TRACK: begin
        if (edge_p0) begin
          cnt_d = CW'(1);
          hp_d  = meas_p0;
          if (cls_p0 == cand_q) begin
            run_upd = sat_run(run_q);
          end else begin
            cand_upd = cls_p0;
            run_upd  = RW'(1);
          end
          cand_d = cand_upd;
          run_d  = run_upd;
          if (run_upd == STABLE_C && cand_upd != note_p1) begin
            note_d = cand_upd;
            chg_d  = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          // Silence: drop back and forget the partial run
          state_d = ST_SILENT;
          cnt_d   = '0;
          cand_d  = NOTE_NONE;
          run_d   = '0;
          if (note_p1 != NOTE_NONE) begin
            note_d = NOTE_NONE;
            chg_d  = 1'b1;
          end
        end else begin
          cnt_d = sat_cnt(cnt_q);
        end
      end
      default: state_d = ST_SILENT;
    endcase

    note_vld_d = (note_d != NOTE_NONE);
  end

  // Stage p1: registered control state and outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_SILENT;
      cnt_q       <= '0;
      run_q       <= '0;
      cand_q      <= NOTE_NONE;
      note_p1     <= NOTE_NONE;
      note_vld_p1 <= 1'b0;
      chg_p1      <= 1'b0;
      hp_p1       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      cand_q      <= cand_d;
      note_p1     <= note_d;
      note_vld_p1 <= note_vld_d;
      chg_p1      <= chg_d;
      hp_p1       <= hp_d;
    end
  end

  assign note        = note_p1;
  assign note_valid  = note_vld_p1;
  assign note_change = chg_p1;
  assign half_period = hp_p1;

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector with scaled-down dividers so the whole
// run stays short.
module tb_tone_detector;
  import tone_pkg::*;

  localparam int P_DO = 478;
  localparam int P_RE = 426;
  localparam int P_MI = 379;
  localparam int TOLV = 10;
  localparam int TMO  = 1000;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        tone_in  = 1'b0;
  logic [1:0]  note;
  logic        note_valid;
  logic        note_change;
  logic [16:0] half_period;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_tog = 0;
  int exp_hp = 0;

  typedef struct {
    logic [1:0] note;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  tone_detector #(
    .DIV_DO(P_DO), .DIV_RE(P_RE), .DIV_MI(P_MI),
    .TOL(TOLV), .STABLE(4), .TIMEOUT(TMO), .CW(17)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .tone_in     (tone_in),
    .note        (note),
    .note_valid  (note_valid),
    .note_change (note_change),
    .half_period (half_period)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait p cycles after the previous toggle, verify the last measurement, toggle
  task automatic tog(input int p, input bit measured);
    repeat (p) @(negedge CLOCK_50);
    check("half_period", 32'(half_period), exp_hp);
    tone_in  = ~tone_in;
    last_tog = cyc;
    if (measured) exp_hp = p;
  endtask

  task automatic expect_chg(input logic [1:0] n, input int dly);
    exp_t e;
    e.note = n;
    e.cyc  = last_tog + dly;
    sb.push_back(e);
  endtask

  task automatic check_note(input logic [1:0] n);
    check("note", 32'(note), 32'(n));
    check("note_valid", 32'(note_valid), 32'(n != 2'b00));
  endtask

  // Monitor: every change pulse must match the next queued expectation
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (resetn && note_change) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_change: got pulse with note %0d at cycle %0d, expected none",
                 note, cyc);
      end else begin
        e = sb.pop_front();
        check("chg_note", 32'(note), 32'(e.note));
        check("chg_valid", 32'(note_valid), 32'(e.note != 2'b00));
        check("chg_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    // Reset held while the input toggles
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge CLOCK_50);
      tone_in = ~tone_in;
      check("rst_note", 32'(note), 0);
      check("rst_valid", 32'(note_valid), 0);
      check("rst_change", 32'(note_change), 0);
      check("rst_hp", 32'(half_period), 0);
    end
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;

    // Lock to do: arming edge, then four measurements decide
    tog(20, 1'b0);
    repeat (3) tog(P_DO, 1'b1);
    tog(P_DO, 1'b1);
    expect_chg(NOTE_DO, 3);
    tog(P_DO, 1'b1);
    check_note(NOTE_DO);

    // do -> mi
    repeat (3) tog(P_MI, 1'b1);
    check_note(NOTE_DO);
    tog(P_MI, 1'b1);
    expect_chg(NOTE_MI, 3);
    tog(P_MI, 1'b1);
    check_note(NOTE_MI);

    // Upper tolerance edge of re is still re
    repeat (3) tog(P_RE + TOLV, 1'b1);
    tog(P_RE + TOLV, 1'b1);
    expect_chg(NOTE_RE, 3);
    tog(P_RE + TOLV, 1'b1);
    check_note(NOTE_RE);

    // One cycle beyond tolerance classifies as none
    repeat (3) tog(P_RE + TOLV + 1, 1'b1);
    tog(P_RE + TOLV + 1, 1'b1);
    expect_chg(NOTE_NONE, 3);
    tog(P_RE + TOLV + 1, 1'b1);
    check_note(NOTE_NONE);

    // Re stream with a single short glitch: no change pulse
    repeat (3) tog(P_RE, 1'b1);
    tog(P_RE, 1'b1);
    expect_chg(NOTE_RE, 3);
    tog(P_RE, 1'b1);
    tog(10, 1'b1);
    repeat (5) tog(P_RE, 1'b1);
    check_note(NOTE_RE);

    // Timeout while locked on re
    expect_chg(NOTE_NONE, 3 + TMO);
    repeat (TMO + 20) @(negedge CLOCK_50);
    check_note(NOTE_NONE);
    check("hp_hold", 32'(half_period), P_RE);
    tog(50, 1'b0);
    tog(P_DO, 1'b1);
    tog(P_DO, 1'b1);

    // Reset mid-run discards the two do measurements
    repeat (5) @(negedge CLOCK_50);
    check("hp_pre_reset", 32'(half_period), P_DO);
    resetn  = 1'b0;
    tone_in = 1'b0;
    exp_hp  = 0;
    repeat (4) @(negedge CLOCK_50);
    check("mid_rst_hp", 32'(half_period), 0);
    check_note(NOTE_NONE);
    resetn = 1'b1;
    tog(30, 1'b0);
    repeat (3) tog(P_DO, 1'b1);
    check_note(NOTE_NONE);
    tog(P_DO, 1'b1);
    expect_chg(NOTE_DO, 3);
    tog(P_DO, 1'b1);
    check_note(NOTE_DO);

    repeat (10) @(negedge CLOCK_50);
    check("pending_changes", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
